// File: rtl/seq_cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package seq_cmp_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic [1:0] {V_EQ, V_GT, V_LT} verdict_t;

  // Index width that never collapses to zero bits for a single-digit build.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_cmp4.sv
// Combinational unsigned compare of one 4-bit digit pair.
module digit_cmp4
  import seq_cmp_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output verdict_t   verdict_o
);

  always_comb begin
    verdict_o = V_EQ;
    if (a_i > b_i)      verdict_o = V_GT;
    else if (a_i < b_i) verdict_o = V_LT;
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial wide magnitude comparator with cascade inputs and start/done handshake.
// Optional macro SEQ_CMP_EARLY_EXIT_EN: finish on the first differing digit.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             eq_in,
  input  logic             gt_in,
  input  logic             lt_in,
  output logic             busy,
  output logic             done,
  output logic             eq_out,
  output logic             gt_out,
  output logic             lt_out
);
  import seq_cmp_pkg::*;

  localparam int             NDIG    = WIDTH / 4;
  localparam int             IW      = clog2_min1(NDIG);
  localparam logic [IW-1:0]  IDX_MAX = IW'(NDIG - 1);

  state_t           state_q, state_d;
  verdict_t         verdict_q, verdict_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             gt_in_q, gt_in_d, lt_in_q, lt_in_d;
  logic             eq_out_q, eq_out_d, gt_out_q, gt_out_d, lt_out_q, lt_out_d;

  logic [3:0]       a_dig [NDIG];
  logic [3:0]       b_dig [NDIG];
  verdict_t         dig_v;
  verdict_t         verdict_scan;
  verdict_t         resolved;
  logic             finish;

  // Cascade equal carries no information beyond gt_in/lt_in both low.
  logic             unused_eq_in;
  assign unused_eq_in = eq_in;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      assign a_dig[gi] = a_q[gi*4 +: 4];
      assign b_dig[gi] = b_q[gi*4 +: 4];
    end
  endgenerate

  digit_cmp4 u_digit_cmp4 (
    .a_i       (a_dig[idx_q]),
    .b_i       (b_dig[idx_q]),
    .verdict_o (dig_v)
  );

  always_comb begin
    verdict_scan = (verdict_q == V_EQ) ? dig_v : verdict_q;
    resolved     = verdict_scan;
    if (verdict_scan == V_EQ) begin
      if (gt_in_q)      resolved = V_GT;
      else if (lt_in_q) resolved = V_LT;
    end
  end

  always_comb begin
    state_d   = state_q;
    verdict_d = verdict_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    gt_in_d   = gt_in_q;
    lt_in_d   = lt_in_q;
    eq_out_d  = eq_out_q;
    gt_out_d  = gt_out_q;
    lt_out_d  = lt_out_q;
    finish    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = (state_q == DONE) ? IDLE : state_q;
        if (start) begin
          state_d   = SCAN;
          a_d       = a;
          b_d       = b;
          gt_in_d   = gt_in;
          lt_in_d   = lt_in;
          idx_d     = IDX_MAX;
          verdict_d = V_EQ;
        end
      end
      SCAN: begin
        verdict_d = verdict_scan;
        if (idx_q == '0) finish = 1'b1;
        else             idx_d  = idx_q - 1'b1;
`ifdef SEQ_CMP_EARLY_EXIT_EN
        if (verdict_q == V_EQ && dig_v != V_EQ) finish = 1'b1;
`endif
        // Results are registered on entry to DONE and held until the next one.
        if (finish) begin
          state_d  = DONE;
          eq_out_d = (resolved == V_EQ);
          gt_out_d = (resolved == V_GT);
          lt_out_d = (resolved == V_LT);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      verdict_q <= V_EQ;
      idx_q     <= IDX_MAX;
      a_q       <= '0;
      b_q       <= '0;
      gt_in_q   <= 1'b0;
      lt_in_q   <= 1'b0;
      eq_out_q  <= 1'b0;
      gt_out_q  <= 1'b0;
      lt_out_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      verdict_q <= verdict_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      gt_in_q   <= gt_in_d;
      lt_in_q   <= lt_in_d;
      eq_out_q  <= eq_out_d;
      gt_out_q  <= gt_out_d;
      lt_out_q  <= lt_out_d;
    end
  end

  assign busy   = (state_q == SCAN);
  assign done   = (state_q == DONE);
  assign eq_out = eq_out_q;
  assign gt_out = gt_out_q;
  assign lt_out = lt_out_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomized self-checking bench for seq_magnitude_comparator (WIDTH=16).
module tb_seq_magnitude_comparator;

  localparam int WIDTH = 16;
  localparam int NDIG  = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             eq_in, gt_in, lt_in;
  logic             busy, done, eq_out, gt_out, lt_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .eq_in  (eq_in),
    .gt_in  (gt_in),
    .lt_in  (lt_in),
    .busy   (busy),
    .done   (done),
    .eq_out (eq_out),
    .gt_out (gt_out),
    .lt_out (lt_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected cycles from accept to done.
  function automatic int model_lat(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    for (int i = NDIG - 1; i >= 0; i--)
      if (((av >> (4 * i)) & 16'hF) != ((bv >> (4 * i)) & 16'hF)) return NDIG - i;
`endif
    return NDIG;
  endfunction

  // Returns {gt, lt, eq}.
  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                           input logic gi, input logic li);
    if (av > bv) return 3'b100;
    if (av < bv) return 3'b010;
    if (gi)      return 3'b100;
    if (li)      return 3'b010;
    return 3'b001;
  endfunction

  // Called at a negedge with the DUT ready to accept at the next posedge.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic gi, input logic li, input bit keep_start, input bit intrude);
    int         lat;
    int         exp_lat;
    logic [2:0] exp_res;
    exp_lat = model_lat(av, bv);
    exp_res = model_res(av, bv, gi, li);
    a = av; b = bv; gt_in = gi; lt_in = li; eq_in = 1'($urandom);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = keep_start;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    gt_in = 1'($urandom); lt_in = 1'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_nodone0"}, 32'(done), 32'd0);
    lat = 0;
    for (int k = 1; k <= NDIG + 3; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (intrude && k == 1) begin
        start = 1'b1; a = 16'hFFFF; b = 16'h0000;
      end
      if (intrude && k == 2) start = keep_start;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, {29'd0, gt_out, lt_out, eq_out}, {29'd0, exp_res});
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    $display("op %s a=%h b=%h gt_in=%b lt_in=%b lat=%0d gt/lt/eq=%b%b%b exp=%b",
             tag, av, bv, gi, li, lat, gt_out, lt_out, eq_out, exp_res);
    if (!keep_start) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_hold"}, {29'd0, gt_out, lt_out, eq_out}, {29'd0, exp_res});
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    eq_in = 1'b0; gt_in = 1'b0; lt_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_flags", {30'd0, busy, done}, 32'd0);
    check("reset_outs", {29'd0, gt_out, lt_out, eq_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("eq_1234", 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("gt_8000", 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("casc_gt", 16'hABCD, 16'hABCD, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("casc_lt", 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("diff_wins", 16'h0010, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("ignore_start", 16'h00F0, 16'h00F1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a scan.
    a = 16'h1234; b = 16'h0000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {30'd0, busy, done}, 32'd0);
    check("midrst_outs", {29'd0, gt_out, lt_out, eq_out}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_nodone", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", {30'd0, busy, done}, 32'd0);
    run_op("after_rst", 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = WIDTH'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (WIDTH'($urandom_range(1, 15)) << (4 * $urandom_range(0, NDIG - 1)));
      endcase
      run_op("rand", ra, rb, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    end

    // Start held high: each DONE cycle accepts the next pair.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) run_op("b2b", 16'hA5A5 + 16'(i), 16'h5A5A, 1'b0, 1'b0, i < 5, 1'b0);
      else            run_op("b2b", 16'h5A5A, 16'hA5A5 + 16'(i), 1'b0, 1'b0, i < 5, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
